// File: rtl/fitof_pipe_if.sv
// Handshake bundle for the integer-to-float pipe:
// operand side (x*) and result side (y*).
interface fitof_pipe_if #(
    parameter int TAG_W = 5
);
    logic [31:0]      x;
    logic [TAG_W-1:0] x_tag;
    logic             x_valid;
    logic             x_ready;
    logic [31:0]      y;
    logic [TAG_W-1:0] y_tag;
    logic             y_valid;
    logic             y_ready;

    modport master (
        output x, x_tag, x_valid, y_ready,
        input  x_ready, y, y_tag, y_valid
    );

    modport slave (
        input  x, x_tag, x_valid, y_ready,
        output x_ready, y, y_tag, y_valid
    );
endinterface

// File: rtl/fitof_pipe.sv
// Three-stage signed int32 -> IEEE-754 single converter
// with valid/ready flow control and a travelling tag.
module fitof_pipe #(
    parameter int TAG_W         = 5,
    parameter bit ROUND_NEAREST = 1'b1
) (
    input logic         clk,
    input logic         rst,
    fitof_pipe_if.slave bus
);
    logic adv1, adv2, adv3;
    logic v1_q, v2_q, v3_q;

    logic             s1_s_q, s1_z_q;
    logic [31:0]      s1_mag_q, s1_mag_d;
    logic [TAG_W-1:0] s1_tag_q;

    logic             s2_s_q, s2_z_q;
    logic [31:0]      s2_n_q, s2_n_d;
    logic [7:0]       s2_e_q, s2_e_d;
    logic [TAG_W-1:0] s2_tag_q;
    logic [4:0]       lz;

    logic [31:0]      y_q, y_d;
    logic [TAG_W-1:0] y_tag_q;

    logic [23:0] sig;
    logic        rup;
    logic [24:0] sum;
    logic [7:0]  e_rnd;
    logic        rnd_unused;

    assign adv3 = ~v3_q | bus.y_ready;
    assign adv2 = ~v2_q | adv3;
    assign adv1 = ~v1_q | adv2;

    assign bus.x_ready = adv1;
    assign bus.y       = y_q;
    assign bus.y_tag   = y_tag_q;
    assign bus.y_valid = v3_q;

    assign s1_mag_d = bus.x[31] ? (32'd0 - bus.x) : bus.x;

    // S1: split the operand into sign, magnitude and zero flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            s1_s_q   <= 1'b0;
            s1_z_q   <= 1'b0;
            s1_mag_q <= '0;
            s1_tag_q <= '0;
        end else if (adv1) begin
            v1_q     <= bus.x_valid;
            s1_s_q   <= bus.x[31];
            s1_z_q   <= (bus.x == 32'd0);
            s1_mag_q <= s1_mag_d;
            s1_tag_q <= bus.x_tag;
        end
    end

    // Leading-zero count: the highest set bit wins
    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (s1_mag_q[i]) lz = 5'(31 - i);
        end
    end

    assign s2_n_d = s1_mag_q << lz;
    assign s2_e_d = 8'd158 - {3'b000, lz};

    // S2: normalise so the leading one sits in bit 31
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q     <= 1'b0;
            s2_s_q   <= 1'b0;
            s2_z_q   <= 1'b0;
            s2_n_q   <= '0;
            s2_e_q   <= '0;
            s2_tag_q <= '0;
        end else if (adv2) begin
            v2_q     <= v1_q;
            s2_s_q   <= s1_s_q;
            s2_z_q   <= s1_z_q;
            s2_n_q   <= s2_n_d;
            s2_e_q   <= s2_e_d;
            s2_tag_q <= s1_tag_q;
        end
    end

    // Round on guard/sticky; a carry-out leaves the fraction zero
    // and bumps the exponent, so only the low 23 sum bits are kept.
    always_comb begin
        sig   = s2_n_q[31:8];
        rup   = ROUND_NEAREST & s2_n_q[7] &
                ((|s2_n_q[6:0]) | sig[0]);
        sum   = {1'b0, sig} + {24'd0, rup};
        e_rnd = s2_e_q + {7'd0, sum[24]};
        y_d   = s2_z_q ? 32'd0 : {s2_s_q, e_rnd, sum[22:0]};
    end

    assign rnd_unused = sum[23];

    // S3: registered result presented to writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q    <= 1'b0;
            y_q     <= '0;
            y_tag_q <= '0;
        end else if (adv3) begin
            v3_q    <= v2_q;
            y_q     <= y_d;
            y_tag_q <= s2_tag_q;
        end
    end
endmodule

// File: tb/tb_fitof_pipe.sv
// Scoreboard bench for fitof_pipe: a round-to-nearest and a
// truncating instance run in lockstep on the same stimulus.
module tb_fitof_pipe;
    localparam int TW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fitof_pipe_if #(.TAG_W(TW)) bus ();
    fitof_pipe_if #(.TAG_W(TW)) bus2 ();

    assign bus2.x       = bus.x;
    assign bus2.x_tag   = bus.x_tag;
    assign bus2.x_valid = bus.x_valid;
    assign bus2.y_ready = bus.y_ready;

    fitof_pipe #(.TAG_W(TW), .ROUND_NEAREST(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    fitof_pipe #(.TAG_W(TW), .ROUND_NEAREST(1'b0)) dut_tr (
        .clk(clk), .rst(rst), .bus(bus2.slave)
    );

    typedef struct {
        logic [31:0]    e_rn;
        logic [31:0]    e_tr;
        logic [TW-1:0]  tag;
        int             cyc;
        bit             strict;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit strict = 0;
    bit dir_v = 0;
    logic [31:0] dir_rn, dir_tr;
    bit hold_p = 0;
    logic [31:0] hold_y;
    logic [TW-1:0] hold_tag;
    int stalls = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic on the magnitude
    function automatic logic [31:0] model(input logic [31:0] x,
                                          input bit rn);
        longint v, m, q, rem, half;
        bit s;
        int p, ex, sh;
        v = longint'($signed(x));
        s = (v < 0);
        m = s ? -v : v;
        if (m == 0) return 32'd0;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        ex = 127 + p;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh = p - 23;
            q = m >> sh;
            rem = m - (q << sh);
            half = 64'sd1 << (sh - 1);
            if (rn && (rem > half || (rem == half && q[0]))) q++;
            if (q == (64'sd1 << 24)) begin
                q = q >> 1;
                ex++;
            end
        end
        return {s, 8'(ex), 23'(q)};
    endfunction

    // Monitor: samples mid-cycle, away from the active edge
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            if (bus.y_valid && hold_p) begin
                chk("hold_y", bus.y, hold_y);
                chk("hold_tag", 32'(bus.y_tag), 32'(hold_tag));
            end
            hold_p = 0;
            if (bus.y_valid !== bus2.y_valid)
                chk("lockstep_valid", 32'(bus2.y_valid),
                    32'(bus.y_valid));
            if (bus.y_valid && bus.y_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'(bus.y_tag), 32'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("y_rn", bus.y, e.e_rn);
                    chk("y_tr", bus2.y, e.e_tr);
                    chk("y_tag", 32'(bus.y_tag), 32'(e.tag));
                    if (e.strict) chk("latency", cyc - e.cyc, 3);
                end
            end else if (bus.y_valid) begin
                hold_p = 1;
                hold_y = bus.y;
                hold_tag = bus.y_tag;
            end
            if (bus.x_valid && bus.x_ready) begin
                e.e_rn = dir_v ? dir_rn : model(bus.x, 1'b1);
                e.e_tr = dir_v ? dir_tr : model(bus.x, 1'b0);
                e.tag = bus.x_tag;
                e.cyc = cyc;
                e.strict = strict;
                sb.push_back(e);
            end
        end
    end

    // Caller sits at posedge+#1; returns at posedge+#1 after accept
    task automatic send(input logic [31:0] x, input logic [TW-1:0] t);
        int n;
        bus.x = x;
        bus.x_tag = t;
        bus.x_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.x_ready && n < 200) begin
            n++;
            stalls++;
            @(negedge clk);
        end
        if (n >= 200) chk("send_timeout", 32'(n), 0);
        @(posedge clk);
        #1;
        bus.x_valid = 1'b0;
    endtask

    task automatic send_dir(input logic [31:0] x,
                            input logic [TW-1:0] t,
                            input logic [31:0] rn,
                            input logic [31:0] tr);
        dir_v = 1;
        dir_rn = rn;
        dir_tr = tr;
        send(x, t);
        dir_v = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain;
        int n;
        bus.y_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", 32'(sb.size()), 0);
    endtask

    initial begin
        int acc;
        bus.x = '0;
        bus.x_tag = '0;
        bus.x_valid = 1'b0;
        bus.y_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_y", bus.y, 0);
        chk("rst_tag", 32'(bus.y_tag), 0);
        chk("rst_valid", 32'(bus.y_valid), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(bus.x_ready), 1);

        strict = 1;
        send_dir(32'd1, 5'd3, 32'h3F800000, 32'h3F800000);
        idle(5);
        send_dir(32'hFFFFFFFF, 5'd9, 32'hBF800000, 32'hBF800000);
        idle(5);
        send_dir(32'd0, 5'd17, 32'h0, 32'h0);
        idle(5);
        send_dir(32'h7FFFFFFF, 5'd1, 32'h4F000000, 32'h4EFFFFFF);
        send_dir(32'h80000000, 5'd2, 32'hCF000000, 32'hCF000000);
        send_dir(32'd16777217, 5'd4, 32'h4B800000, 32'h4B800000);
        send_dir(32'd16777219, 5'd5, 32'h4B800002, 32'h4B800001);
        idle(5);

        stalls = 0;
        for (int i = 0; i < 8; i++) send($urandom, 5'(i));
        chk("stream_stalls", 32'(stalls), 0);
        idle(6);
        chk("stream_empty", 32'(sb.size()), 0);
        strict = 0;

        bus.y_ready = 1'b0;
        for (int i = 0; i < 3; i++) send($urandom, 5'(8 + i));
        bus.x = $urandom;
        bus.x_tag = 5'd11;
        bus.x_valid = 1'b1;
        @(negedge clk);
        chk("full_x_ready", 32'(bus.x_ready), 0);
        chk("full_count", 32'(sb.size()), 3);
        idle(4);
        bus.x_valid = 1'b0;
        acc = sb.size();
        chk("still_full", 32'(acc), 3);
        drain();

        for (int i = 0; i < 16; i++) begin
            bus.x = $urandom;
            bus.x_tag = 5'(i);
            bus.x_valid = (i % 2 == 0);
            bus.y_ready = (i % 2 == 1);
            idle(1);
        end
        bus.x_valid = 1'b0;
        drain();

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: bus.x = $urandom_range(0, 255);
                1: bus.x = 32'd0 - $urandom_range(0, 255);
                2: bus.x = 32'h00FFFFFF + $urandom_range(0, 15);
                default: bus.x = $urandom;
            endcase
            bus.x_tag = 5'($urandom);
            bus.x_valid = $urandom_range(0, 3) != 0;
            bus.y_ready = $urandom_range(0, 3) != 0;
            idle(1);
        end
        bus.x_valid = 1'b0;
        drain();

        strict = 1;
        for (int i = 0; i < 3; i++) send($urandom, 5'(20 + i));
        chk("pre_rst_valid", 32'(bus.y_valid), 1);
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(bus.y_valid), 0);
        chk("async_y", bus.y, 0);
        sb.delete();
        hold_p = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        chk("no_stale", 32'(bus.y_valid), 0);
        send_dir(32'd2, 5'd30, 32'h40000000, 32'h40000000);
        idle(6);
        chk("final_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
